// File: rtl/noc_ring_out_arbiter_if.sv
// Handshake bundle between the three router inputs and one output-port arbiter.
// slave is the arbiter side; master is the input/downstream side that drives it.
interface noc_ring_out_arbiter_if #(
  parameter int unsigned CntW = 3
);
  logic [2:0]      req_i;
  logic [2:0]      head_i;
  logic [2:0]      tail_i;
  logic            credit_i;
  logic [2:0]      gnt_o;
  logic [1:0]      sel_o;
  logic            valid_o;
  logic            locked_o;
  logic [CntW-1:0] credits_o;
  logic            err_o;

  modport master (
    output req_i, head_i, tail_i, credit_i,
    input  gnt_o, sel_o, valid_o, locked_o, credits_o, err_o
  );

  modport slave (
    input  req_i, head_i, tail_i, credit_i,
    output gnt_o, sel_o, valid_o, locked_o, credits_o, err_o
  );
endinterface

// File: rtl/noc_ring_out_arbiter.sv
// One ring-router output port: round-robin packet arbitration, wormhole lock
// from head to tail, and a downstream credit counter gating every grant.
module noc_ring_out_arbiter #(
  parameter int unsigned Credits     = 4,
  parameter logic [2:0]  PortsEnable = 3'b111,
  parameter int unsigned CntW        = $clog2(Credits + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  noc_ring_out_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CntW-1:0] CRED_MAX = CntW'(Credits);

  state_t          state;
  logic [1:0]      owner, ptr;
  logic [CntW-1:0] credits;
  logic            err;

  logic [2:0] m, cand, gnt;
  logic [1:0] p0, p1, p2, cur;
  logic       has_cred, valid;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign m        = bus.req_i & PortsEnable;
  assign cand     = m & bus.head_i;
  assign has_cred = (credits != '0);
  assign p0       = ptr;
  assign p1       = inc3(ptr);
  assign p2       = inc3(p1);

  // Grant is combinational so a flit moves in the same cycle it is presented.
  always_comb begin
    gnt = '0;
    cur = owner;
    if (!rst) begin
      case (state)
        IDLE: begin
          if      (cand[p0]) cur = p0;
          else if (cand[p1]) cur = p1;
          else               cur = p2;
          if (|cand && has_cred) gnt[cur] = 1'b1;
        end
        LOCKED: if (m[owner] && has_cred) gnt[owner] = 1'b1;
        default: ;
      endcase
    end
  end

  assign valid = |gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 2'd0;
      ptr     <= 2'd0;
      credits <= CRED_MAX;
      err     <= 1'b0;
    end else begin
      if (valid) owner <= cur;
      case (state)
        IDLE: begin
          if (valid) begin
            if (bus.tail_i[cur]) ptr   <= inc3(cur);
            else                 state <= LOCKED;
          end
          // Body flits cannot open a packet.
          if (|(m & ~bus.head_i)) err <= 1'b1;
        end
        LOCKED: begin
          if (valid) begin
            if (bus.tail_i[owner]) begin
              state <= IDLE;
              ptr   <= inc3(owner);
            end
            if (bus.head_i[owner]) err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // A credit beyond the buffer depth means downstream lost track.
      if (valid && !bus.credit_i) begin
        credits <= credits - CntW'(1);
      end else if (bus.credit_i && !valid) begin
        if (credits == CRED_MAX) err <= 1'b1;
        else                     credits <= credits + CntW'(1);
      end
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.valid_o   = valid;
  assign bus.sel_o     = valid ? cur : owner;
  assign bus.locked_o  = (state == LOCKED);
  assign bus.credits_o = credits;
  assign bus.err_o     = err;

endmodule

// File: tb/tb_noc_ring_out_arbiter.sv
// Directed bench: three arbiter instances (default, Credits=2, West masked)
// driven by one linear stimulus sequence with immediate-assertion checks.
module tb_noc_ring_out_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  noc_ring_out_arbiter_if #(.CntW(3)) if0 ();
  noc_ring_out_arbiter_if #(.CntW(2)) if1 ();
  noc_ring_out_arbiter_if #(.CntW(3)) if2 ();

  noc_ring_out_arbiter #(.Credits(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
  noc_ring_out_arbiter #(.Credits(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
  noc_ring_out_arbiter #(.Credits(4), .PortsEnable(3'b110)) u2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    if0.req_i = '0; if0.head_i = '0; if0.tail_i = '0; if0.credit_i = 1'b0;
    if1.req_i = '0; if1.head_i = '0; if1.tail_i = '0; if1.credit_i = 1'b0;
    if2.req_i = '0; if2.head_i = '0; if2.tail_i = '0; if2.credit_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    // Requests during reset must not be granted.
    if0.req_i = 3'b111; if0.head_i = 3'b111; if0.tail_i = 3'b111;
    #2;
    chk("rst_gnt",     32'(if0.gnt_o),     32'h0);
    chk("rst_valid",   32'(if0.valid_o),   32'h0);
    chk("rst_sel",     32'(if0.sel_o),     32'h0);
    chk("rst_locked",  32'(if0.locked_o),  32'h0);
    chk("rst_credits", 32'(if0.credits_o), 32'h4);
    chk("rst_err",     32'(if0.err_o),     32'h0);
    chk("rst_cred_u1", 32'(if1.credits_o), 32'h2);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single-flit round robin
    #1;
    chk("rr_gnt0", 32'(if0.gnt_o), 32'h1);
    chk("rr_sel0", 32'(if0.sel_o), 32'h0);
    chk("rr_cr0",  32'(if0.credits_o), 32'h4);
    @(negedge clk); #1;
    chk("rr_gnt1", 32'(if0.gnt_o), 32'h2);
    chk("rr_sel1", 32'(if0.sel_o), 32'h1);
    chk("rr_cr1",  32'(if0.credits_o), 32'h3);
    @(negedge clk); #1;
    chk("rr_gnt2", 32'(if0.gnt_o), 32'h4);
    chk("rr_sel2", 32'(if0.sel_o), 32'h2);
    chk("rr_cr2",  32'(if0.credits_o), 32'h2);
    @(negedge clk);
    clear_all(); #1;
    chk("rr_cr3",     32'(if0.credits_o), 32'h1);
    chk("rr_valid",   32'(if0.valid_o),   32'h0);
    chk("rr_sel_hold", 32'(if0.sel_o),    32'h2);
    if0.credit_i = 1'b1;
    repeat (3) @(negedge clk);
    if0.credit_i = 1'b0; #1;
    chk("rr_refill", 32'(if0.credits_o), 32'h4);
    chk("rr_err",    32'(if0.err_o),     32'h0);

    // Wormhole: West 3-flit packet while East holds a single-flit packet
    if0.req_i = 3'b011; if0.head_i = 3'b011; if0.tail_i = 3'b010; #1;
    chk("wh_gnt_h",  32'(if0.gnt_o),    32'h1);
    chk("wh_lock_h", 32'(if0.locked_o), 32'h0);
    @(negedge clk);
    if0.head_i = 3'b010; #1;
    chk("wh_gnt_b",  32'(if0.gnt_o),    32'h1);
    chk("wh_lock_b", 32'(if0.locked_o), 32'h1);
    @(negedge clk);
    if0.tail_i = 3'b011; #1;
    chk("wh_gnt_t",  32'(if0.gnt_o),    32'h1);
    chk("wh_lock_t", 32'(if0.locked_o), 32'h1);
    @(negedge clk);
    // West offers a new packet too; pointer now favours East.
    if0.head_i = 3'b011; if0.tail_i = 3'b011; #1;
    chk("wh_gnt_e",  32'(if0.gnt_o),    32'h2);
    chk("wh_sel_e",  32'(if0.sel_o),    32'h1);
    chk("wh_lock_e", 32'(if0.locked_o), 32'h0);
    @(negedge clk);
    clear_all(); #1;
    chk("wh_cr",  32'(if0.credits_o), 32'h0);
    chk("wh_err", 32'(if0.err_o),     32'h0);
    if0.credit_i = 1'b1;
    repeat (4) @(negedge clk);
    if0.credit_i = 1'b0; #1;
    chk("wh_refill", 32'(if0.credits_o), 32'h4);

    // Simultaneous credit and grant, then credit overflow
    if0.req_i = 3'b100; if0.head_i = 3'b100; if0.tail_i = 3'b100;
    repeat (3) @(negedge clk);
    if0.credit_i = 1'b1; #1;
    chk("sim_gnt", 32'(if0.gnt_o),     32'h4);
    chk("sim_cr0", 32'(if0.credits_o), 32'h1);
    @(negedge clk);
    clear_all(); #1;
    chk("sim_cr1", 32'(if0.credits_o), 32'h1);
    if0.credit_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("ovf_cr_pre",  32'(if0.credits_o), 32'h4);
    chk("ovf_err_pre", 32'(if0.err_o),     32'h0);
    @(negedge clk);
    if0.credit_i = 1'b0; #1;
    chk("ovf_cr",  32'(if0.credits_o), 32'h4);
    chk("ovf_err", 32'(if0.err_o),     32'h1);

    // Credit exhaustion on the Credits=2 instance: Local 4-flit packet
    if1.req_i = 3'b100; if1.head_i = 3'b100; if1.tail_i = 3'b000; #1;
    chk("ex_gnt1", 32'(if1.gnt_o), 32'h4);
    @(negedge clk);
    if1.head_i = 3'b000; #1;
    chk("ex_gnt2", 32'(if1.gnt_o), 32'h4);
    @(negedge clk); #1;
    chk("ex_gnt3",  32'(if1.gnt_o),     32'h0);
    chk("ex_cr3",   32'(if1.credits_o), 32'h0);
    chk("ex_lock3", 32'(if1.locked_o),  32'h1);
    @(negedge clk);
    if1.credit_i = 1'b1; #1;
    chk("ex_gnt4", 32'(if1.gnt_o), 32'h0);
    @(negedge clk);
    if1.credit_i = 1'b0; #1;
    chk("ex_gnt5", 32'(if1.gnt_o),     32'h4);
    chk("ex_cr5",  32'(if1.credits_o), 32'h1);
    @(negedge clk); #1;
    chk("ex_gnt6", 32'(if1.gnt_o),     32'h0);
    chk("ex_cr6",  32'(if1.credits_o), 32'h0);
    if1.credit_i = 1'b1;
    @(negedge clk);
    if1.credit_i = 1'b0; if1.tail_i = 3'b100; #1;
    chk("ex_gnt_tail", 32'(if1.gnt_o), 32'h4);
    @(negedge clk);
    clear_all(); #1;
    chk("ex_unlock", 32'(if1.locked_o), 32'h0);
    chk("ex_err",    32'(if1.err_o),    32'h0);

    // Mask and IDLE body-flit error on the West-disabled instance
    if2.req_i = 3'b001; if2.head_i = 3'b001; if2.tail_i = 3'b001; #1;
    chk("msk_gnt",   32'(if2.gnt_o),   32'h0);
    chk("msk_valid", 32'(if2.valid_o), 32'h0);
    @(negedge clk); #1;
    chk("msk_err", 32'(if2.err_o), 32'h0);
    if2.req_i = 3'b010; if2.head_i = 3'b000; if2.tail_i = 3'b000; #1;
    chk("perr_gnt", 32'(if2.gnt_o), 32'h0);
    @(negedge clk);
    clear_all(); #1;
    chk("perr_err", 32'(if2.err_o), 32'h1);

    // Reset while East holds the lock
    if0.req_i = 3'b010; if0.head_i = 3'b010; if0.tail_i = 3'b000; #1;
    chk("rm_gnt_h", 32'(if0.gnt_o), 32'h2);
    @(negedge clk);
    if0.head_i = 3'b000; #1;
    chk("rm_gnt_b",  32'(if0.gnt_o),    32'h2);
    chk("rm_lock_b", 32'(if0.locked_o), 32'h1);
    chk("rm_cr_b",   32'(if0.credits_o), 32'h3);
    rst = 1'b1; #1;
    chk("rm_lock", 32'(if0.locked_o),  32'h0);
    chk("rm_gnt",  32'(if0.gnt_o),     32'h0);
    chk("rm_valid", 32'(if0.valid_o),  32'h0);
    chk("rm_cr",   32'(if0.credits_o), 32'h4);
    chk("rm_err",  32'(if0.err_o),     32'h0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rm_body_gnt",  32'(if0.gnt_o),    32'h0);
    chk("rm_body_lock", 32'(if0.locked_o), 32'h0);
    @(negedge clk); #1;
    chk("rm_body_err", 32'(if0.err_o),     32'h1);
    chk("rm_body_cr",  32'(if0.credits_o), 32'h4);
    clear_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
